stream_mux_n: RTL and testbench

- Parametrised N:1 stream multiplexer that succeeds the gate-level 2:1 mux in the gates library.
- Generalised in data width, input count and selection mode: static select, or round-robin arbitration.
- Each input has a valid/ready handshake; the output is a single registered stage.
- Used wherever several producer streams share one consumer path.

---
 rtl/stream_mux_n.sv | 215 +++++++++++++++++++++
 tb/tb_stream_mux_n.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_n.sv
// -----------------------------------------------------------------------------
// stream_mux_n
//
// Parametrised N:1 stream multiplexer with a single registered output stage.
// Each input channel has its own valid/ready handshake. The channel that loads
// the output register is chosen either statically (mode=0, channel = sel) or
// by round-robin arbitration (mode=1, search starts after the last winner).
//
// Build option:
//   STREAM_MUX_LOCK_EN  adds in_last/out_last. In round-robin mode a channel
//                       that sends a beat with in_last=0 keeps the grant until
//                       its in_last=1 beat has been accepted (packet lock).
//
// Parameters:
//   WIDTH   data bits per channel
//   NUM_IN  number of input channels (>= 2)
//   SEL_W   channel index width, derived from NUM_IN
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst        synchronous reset, active-high
//   in_data    packed input data, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (at most one bit high)
//   in_last    per-channel end-of-packet marker (STREAM_MUX_LOCK_EN only)
//   mode       0 = static select via sel, 1 = round-robin
//   sel        channel index used in mode 0 (values >= NUM_IN never grant)
//   out_data   registered output data
//   out_valid  output register holds a beat
//   out_ready  consumer accepts the held beat
//   out_chan   index of the channel that produced out_data
//   out_last   registered copy of in_last (STREAM_MUX_LOCK_EN only)
// -----------------------------------------------------------------------------
module stream_mux_n #(
   parameter int WIDTH  = 8,
   parameter int NUM_IN = 4,
   localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [NUM_IN-1:0]       in_valid,
   output logic [NUM_IN-1:0]       in_ready,
`ifdef STREAM_MUX_LOCK_EN
   input  logic [NUM_IN-1:0]       in_last,
`endif
   input  logic                    mode,
   input  logic [SEL_W-1:0]        sel,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [SEL_W-1:0]        out_chan
`ifdef STREAM_MUX_LOCK_EN
   ,
   output logic                    out_last
`endif
);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [WIDTH-1:0]  out_data_reg;
   logic              out_valid_reg;
   logic [SEL_W-1:0]  out_chan_reg;
   logic [SEL_W-1:0]  ptr_reg;          // last round-robin winner
`ifdef STREAM_MUX_LOCK_EN
   logic              out_last_reg;
   logic              lock_active_reg;  // a packet is in progress in mode 1
   logic [SEL_W-1:0]  lock_chan_reg;    // channel owning the packet
`endif

   // ------------------------------------------------------------------------
   // Combinational arbitration
   // ------------------------------------------------------------------------
   logic              load_en;
   logic [NUM_IN-1:0] sel_hit;          // one-hot decode of sel, empty if out of range
   logic              rr_found;
   logic [SEL_W-1:0]  rr_grant;
   logic              grant_found;
   logic [SEL_W-1:0]  grant_idx;
   logic [NUM_IN-1:0] grant_vec;
   logic [WIDTH-1:0]  grant_data;
   logic              xfer;
`ifdef STREAM_MUX_LOCK_EN
   logic              grant_last;
`endif

   // The output register can take a beat when empty or being drained now.
   assign load_en = !out_valid_reg || out_ready;

   // Decoding sel against every legal index means an out-of-range sel simply
   // matches nothing, so no explicit range comparison is needed.
   generate
      for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_sel_dec
         assign sel_hit[gi] = (sel == SEL_W'(gi));
      end
   endgenerate

   // Round-robin search: walk ptr+1, ptr+2, ... with explicit wrap at NUM_IN-1
   // so non-power-of-two channel counts work; the first valid channel wins.
   always_comb begin
      logic [SEL_W-1:0] rr_cand;
      rr_found = 1'b0;
      rr_grant = '0;
      rr_cand  = ptr_reg;
      for (int k = 0; k < NUM_IN; k++) begin
         if (rr_cand == SEL_W'(NUM_IN - 1)) begin
            rr_cand = '0;
         end else begin
            rr_cand = rr_cand + 1'b1;
         end
         if (!rr_found && in_valid[rr_cand]) begin
            rr_found = 1'b1;
            rr_grant = rr_cand;
         end
      end
   end

   // Final grant for the current mode.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      if (!mode) begin
         grant_found = |(sel_hit & in_valid);
         grant_idx   = sel;
      end else begin
`ifdef STREAM_MUX_LOCK_EN
         if (lock_active_reg) begin
            // Mid-packet: only the owning channel may continue.
            grant_found = in_valid[lock_chan_reg];
            grant_idx   = lock_chan_reg;
         end else begin
            grant_found = rr_found;
            grant_idx   = rr_grant;
         end
`else
         grant_found = rr_found;
         grant_idx   = rr_grant;
`endif
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_ready
         assign grant_vec[gi] = grant_found && (grant_idx == SEL_W'(gi));
         // Mode 0 raises ready on sel regardless of valid; mode 1 only on the
         // granted (hence valid) channel. Nothing is ready during reset.
         assign in_ready[gi]  = !rst && load_en && (mode ? grant_vec[gi] : sel_hit[gi]);
      end
   endgenerate

   // One-hot AND-OR data selection from the grant vector.
   always_comb begin
      grant_data = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         grant_data = grant_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant_vec[i]}});
      end
   end

`ifdef STREAM_MUX_LOCK_EN
   assign grant_last = |(in_last & grant_vec);
`endif

   assign xfer = load_en && grant_found;

   // ------------------------------------------------------------------------
   // Output register, pointer and lock
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         out_data_reg    <= '0;
         out_valid_reg   <= 1'b0;
         out_chan_reg    <= '0;
         ptr_reg         <= SEL_W'(NUM_IN - 1);  // first round-robin grant is ch0
`ifdef STREAM_MUX_LOCK_EN
         out_last_reg    <= 1'b0;
         lock_active_reg <= 1'b0;
         lock_chan_reg   <= '0;
`endif
      end else if (load_en) begin
         if (xfer) begin
            out_data_reg  <= grant_data;
            out_valid_reg <= 1'b1;
            out_chan_reg  <= grant_idx;
`ifdef STREAM_MUX_LOCK_EN
            out_last_reg  <= grant_last;
            if (mode) begin
               if (grant_last) begin
                  // Packet finished: release and advance the fairness pointer.
                  lock_active_reg <= 1'b0;
                  ptr_reg         <= grant_idx;
               end else begin
                  lock_active_reg <= 1'b1;
                  lock_chan_reg   <= grant_idx;
               end
            end
`else
            if (mode) begin
               ptr_reg <= grant_idx;
            end
`endif
         end else begin
            out_valid_reg <= 1'b0;
         end
      end
   end

   assign out_data  = out_data_reg;
   assign out_valid = out_valid_reg;
   assign out_chan  = out_chan_reg;
`ifdef STREAM_MUX_LOCK_EN
   assign out_last  = out_last_reg;
`endif

endmodule

// File: tb/tb_stream_mux_n.sv
// -----------------------------------------------------------------------------
// tb_stream_mux_n
//
// Directed bench for stream_mux_n (WIDTH=8, NUM_IN=4). A behavioural model of
// the output register, round-robin pointer and (optionally) packet lock is
// advanced once per cycle on the falling edge, where it is also compared with
// the DUT. Directed sequences additionally check hand-computed literals.
// Build option STREAM_MUX_LOCK_EN enables the in_last/out_last checks.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_stream_mux_n;
   localparam int WIDTH  = 8;
   localparam int NUM_IN = 4;
   localparam int SEL_W  = 2;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [NUM_IN*WIDTH-1:0] in_data;
   logic [NUM_IN-1:0]       in_valid;
   logic [NUM_IN-1:0]       in_ready;
   logic [NUM_IN-1:0]       in_last;
   logic                    mode;
   logic [SEL_W-1:0]        sel;
   logic [WIDTH-1:0]        out_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [SEL_W-1:0]        out_chan;
   logic                    out_last;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   stream_mux_n #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
`ifdef STREAM_MUX_LOCK_EN
      .in_last   (in_last),
`endif
      .mode      (mode),
      .sel       (sel),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_chan  (out_chan)
`ifdef STREAM_MUX_LOCK_EN
      ,
      .out_last  (out_last)
`endif
   );

`ifndef STREAM_MUX_LOCK_EN
   assign out_last = 1'b0;
`endif

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // ------------------------------------------------------------------------
   // Behavioural model
   // ------------------------------------------------------------------------
   logic              m_live  = 1'b0;
   logic              m_valid;
   logic [WIDTH-1:0]  m_data;
   int                m_chan;
   logic              m_last;
   logic              m_clean;     // still holding reset contents
   int                m_ptr;
   logic              m_lock;
   int                m_lock_ch;
   logic [NUM_IN-1:0] er;
   int                g;
   logic              le;

   task automatic model_reset();
      m_valid   = 1'b0;
      m_data    = '0;
      m_chan    = 0;
      m_last    = 1'b0;
      m_clean   = 1'b1;
      m_ptr     = NUM_IN - 1;
      m_lock    = 1'b0;
      m_lock_ch = 0;
   endtask

   always @(negedge clk) begin
      if (m_live) begin
         er = '0;
         g  = -1;
         le = 1'b0;
         if (!rst) begin
            le = !m_valid || out_ready;
            if (!mode) begin
               if (int'(sel) < NUM_IN) begin
                  if (le) er[sel] = 1'b1;
                  if (in_valid[sel]) g = int'(sel);
               end
            end else begin
`ifdef STREAM_MUX_LOCK_EN
               if (m_lock) begin
                  if (in_valid[m_lock_ch]) g = m_lock_ch;
               end else
`endif
               for (int k = 1; k <= NUM_IN; k++) begin
                  if (g < 0 && in_valid[(m_ptr + k) % NUM_IN]) g = (m_ptr + k) % NUM_IN;
               end
               if (le && g >= 0) er[g] = 1'b1;
            end
         end
         check("in_ready", 32'(in_ready), 32'(er));
         check("out_valid", 32'(out_valid), 32'(m_valid));
         if (m_valid || m_clean) begin
            check("out_data", 32'(out_data), 32'(m_data));
            check("out_chan", 32'(out_chan), 32'(m_chan));
         end
`ifdef STREAM_MUX_LOCK_EN
         if (m_valid) check("out_last", 32'(out_last), 32'(m_last));
`endif
         // Advance to the state after the coming rising edge.
         if (rst) begin
            model_reset();
         end else if (le) begin
            if (g >= 0) begin
               $display("xfer ch=%0d data=%02h mode=%0d", g, in_data[g*WIDTH +: WIDTH], mode);
               m_valid = 1'b1;
               m_data  = in_data[g*WIDTH +: WIDTH];
               m_chan  = g;
               m_last  = in_last[g];
               m_clean = 1'b0;
               if (mode) begin
`ifdef STREAM_MUX_LOCK_EN
                  if (in_last[g]) begin
                     m_lock = 1'b0;
                     m_ptr  = g;
                  end else begin
                     m_lock    = 1'b1;
                     m_lock_ch = g;
                  end
`else
                  m_ptr = g;
`endif
               end
            end else begin
               m_valid = 1'b0;
            end
         end
      end else if (rst) begin
         model_reset();
         m_live = 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Directed stimulus with literal expectations
   // ------------------------------------------------------------------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_beat(input string name, input int chan, input logic [7:0] data);
      check({name, "_valid"}, 32'(out_valid), 32'd1);
      check({name, "_chan"}, 32'(out_chan), 32'(chan));
      check({name, "_data"}, 32'(out_data), 32'(data));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_seq[4];
      rst       = 1'b1;
      in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
      in_valid  = 4'hF;
      in_last   = '0;
      mode      = 1'b1;
      sel       = '0;
      out_ready = 1'b1;

      // Reset state, in_ready held low while rst is high.
      step();
      step();
      check("rst_in_ready", 32'(in_ready), 32'h0);
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_out_data", 32'(out_data), 32'h0);
      check("rst_out_chan", 32'(out_chan), 32'h0);
      rst = 1'b0;
      #1;
      check("rr_first_ready", 32'(in_ready), 32'b0001);
      step();
      expect_beat("rr_first", 0, 8'h10);

      // Round-robin fairness with all channels valid.
      for (int i = 1; i <= 5; i++) begin
         step();
         expect_beat("rr_all", i % 4, 8'h10 + 8'(i % 4));
      end

      // Only ch1 and ch3 valid; pointer sits at ch1.
      in_valid   = 4'b1010;
      exp_seq[0] = 3; exp_seq[1] = 1; exp_seq[2] = 3; exp_seq[3] = 1;
      for (int i = 0; i < 4; i++) begin
         step();
         expect_beat("rr_13", exp_seq[i], 8'h10 + 8'(exp_seq[i]));
      end

      // Static select of ch2.
      mode     = 1'b0;
      sel      = 2'd2;
      in_data  = {8'h13, 8'hA5, 8'h11, 8'h10};
      in_valid = 4'hF;
      #1;
      check("st_ready", 32'(in_ready), 32'b0100);
      step();
      expect_beat("st_a", 2, 8'hA5);
      check("st_ready2", 32'(in_ready), 32'b0100);
      step();
      expect_beat("st_b", 2, 8'hA5);

      // sel=3 with ch3 not valid: ready still raised, output empties.
      sel      = 2'd3;
      in_valid = 4'b0111;
      #1;
      check("st_inv_ready", 32'(in_ready), 32'b1000);
      step();
      check("st_inv_valid", 32'(out_valid), 32'h0);
      sel      = 2'd2;
      in_valid = 4'b0000;
      #1;
      check("st_noval_ready", 32'(in_ready), 32'b0100);
      step();
      check("st_noval_valid", 32'(out_valid), 32'h0);

      // Back to round-robin: mode 0 beats must not have moved the pointer (ch1).
      mode     = 1'b1;
      in_valid = 4'hF;
      step();
      expect_beat("rr_resume", 2, 8'hA5);

      // Backpressure for three cycles.
      out_ready = 1'b0;
      #1;
      check("bp_ready", 32'(in_ready), 32'h0);
      for (int i = 0; i < 3; i++) begin
         step();
         expect_beat("bp_hold", 2, 8'hA5);
         check("bp_ready_hold", 32'(in_ready), 32'h0);
      end
      out_ready = 1'b1;
      #1;
      check("bp_release_ready", 32'(in_ready), 32'b1000);
      step();
      expect_beat("bp_drain", 3, 8'h13);

      // Reset while a stalled beat is held.
      out_ready = 1'b0;
      step();
      expect_beat("mid_hold", 3, 8'h13);
      rst = 1'b1;
      step();
      check("mid_rst_valid", 32'(out_valid), 32'h0);
      rst       = 1'b0;
      out_ready = 1'b1;
      step();
      expect_beat("mid_restart", 0, 8'h10);

      // Mixed traffic checked by the model only.
      for (int c = 0; c < 64; c++) begin
         in_data   = $urandom;
         in_valid  = 4'((c * 7 + (c >> 2)) % 16);
         out_ready = (c % 3) != 0;
         mode      = ((c >> 4) % 2) == 1;
         sel       = 2'(c % 4);
         in_last   = 4'($urandom_range(0, 15));
         step();
      end

`ifdef STREAM_MUX_LOCK_EN
      // Packet lock: ch0 sends three beats (last on the third) while ch1 waits.
      rst = 1'b1;
      step();
      rst       = 1'b0;
      mode      = 1'b1;
      out_ready = 1'b1;
      in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
      in_valid  = 4'b0011;
      for (int b = 0; b < 4; b++) begin
         in_last = {3'b001, (b == 2)};
         step();
         if (b < 3) begin
            expect_beat("lock_ch0", 0, 8'h10);
            check("lock_last", 32'(out_last), 32'(b == 2));
         end else begin
            expect_beat("lock_ch1", 1, 8'h11);
         end
      end
`endif

      in_valid = '0;
      step();
      step();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
